ab_selector: RTL and testbench

Butterfly address sequencer for a radix-2 FFT/NTT datapath of size N = 2^log_n. For one selected stage it walks every butterfly in order and outputs two indices. bunch_index is the butterfly group. bfly_index is the position inside that group. The downstream A/B operand selector derives a = bunch*2^(stage+1) + bfly and b = a + 2^stage. The block sits between the FFT control FSM and the complex_butterfly memory-address logic.

---
 rtl/ab_pkg.sv | 34 +++
 rtl/ab_counter.sv | 48 ++++
 rtl/ab_selector.sv | 115 +++++++++++
 tb/tb_ab_selector.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ab_pkg.sv
// rtl/ab_pkg.sv - shared widths, FSM state type and a/b address helper for the butterfly sequencer
// Contents: IDX_W, LOGN_W, ab_state_t, ab_addr_t, calc_ab_addr()
package ab_pkg;

    localparam int IDX_W  = 15;
    localparam int LOGN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ab_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] a;
        logic [IDX_W-1:0] b;
    } ab_addr_t;

    // a = bunch * 2^(stage+1) + bfly, b = a + 2^stage.
    // bfly < 2^stage, so the low bits of bunch<<(stage+1) are free for bfly.
    function automatic ab_addr_t calc_ab_addr(
        input logic [IDX_W-1:0]  bunch,
        input logic [IDX_W-1:0]  bfly,
        input logic [LOGN_W-1:0] stage
    );
        ab_addr_t         r;
        logic [IDX_W-1:0] span;
        span = {{(IDX_W-1){1'b0}}, 1'b1} << stage;
        r.a  = (bunch << (int'(stage) + 1)) + bfly;
        r.b  = r.a + span;
        return r;
    endfunction

endpackage

// File: rtl/ab_counter.sv
// rtl/ab_counter.sv - two-level nested wrap counter (bfly inner, bunch outer) with last-butterfly flag
// Ports: clk, clear (sync, highest priority), step (advance one butterfly),
//        span_last / bunch_last (inclusive limits), bfly_index, bunch_index, last
module ab_counter #(
    parameter int IDX_W = 15
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             step,
    input  logic [IDX_W-1:0] span_last,
    input  logic [IDX_W-1:0] bunch_last,
    output logic [IDX_W-1:0] bfly_index,
    output logic [IDX_W-1:0] bunch_index,
    output logic             last
);

    import ab_pkg::*;

    localparam logic [IDX_W-1:0] ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    logic bfly_at_end;
    logic bunch_at_end;

    assign bfly_at_end  = (bfly_index == span_last);
    assign bunch_at_end = (bunch_index == bunch_last);
    assign last         = bfly_at_end && bunch_at_end;

    // Stepping on the last butterfly wraps both levels back to (0,0); the
    // owner decides whether to step there at all.
    always_ff @(posedge clk) begin
        if (clear) begin
            bfly_index  <= '0;
            bunch_index <= '0;
        end else if (step) begin
            if (bfly_at_end) begin
                bfly_index <= '0;
                if (bunch_at_end) begin
                    bunch_index <= '0;
                end else begin
                    bunch_index <= bunch_index + ONE;
                end
            end else begin
                bfly_index <= bfly_index + ONE;
            end
        end
    end

endmodule

// File: rtl/ab_selector.sv
// rtl/ab_selector.sv - radix-2 FFT/NTT butterfly address sequencer for one stage
// Ports: clk, reset (sync, active-high), start (level), en (advance in RUN),
//        log_n / stage / wrap (latched on start), bfly_index, bunch_index (registered)
module ab_selector #(
    parameter int IDX_W  = 15,
    parameter int LOGN_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              en,
    input  logic [LOGN_W-1:0] log_n,
    input  logic [LOGN_W-1:0] stage,
    input  logic              wrap,
    output logic [IDX_W-1:0]  bfly_index,
    output logic [IDX_W-1:0]  bunch_index
);

    import ab_pkg::*;

    localparam logic [IDX_W-1:0]  ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [LOGN_W-1:0] L_ONE = {{(LOGN_W-1){1'b0}}, 1'b1};

    ab_state_t state_q;
    ab_state_t state_d;

    // Latched, already clamped configuration. The bunch shift (L-S-1) is
    // stored directly so an all-zero reset config gives 1 bunch of span 1.
    logic [LOGN_W-1:0] stage_q;
    logic [LOGN_W-1:0] bunch_shift_q;
    logic              wrap_q;

    logic [LOGN_W-1:0] l_eff;
    logic [LOGN_W-1:0] s_eff;

    logic [IDX_W-1:0]  span_last;
    logic [IDX_W-1:0]  bunch_last;

    logic              fsm_clear;
    logic              step;
    logic              last;

    // log_n = 0 runs as a 2-point transform; stage is capped at the final stage.
    always_comb begin
        l_eff = (log_n == '0) ? L_ONE : log_n;
        s_eff = (stage >= l_eff) ? (l_eff - L_ONE) : stage;
    end

    assign span_last  = (ONE << stage_q) - ONE;
    assign bunch_last = (ONE << bunch_shift_q) - ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            stage_q       <= '0;
            bunch_shift_q <= '0;
            wrap_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                stage_q       <= s_eff;
                bunch_shift_q <= l_eff - s_eff - L_ONE;
                wrap_q        <= wrap;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        fsm_clear = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            IDLE: begin
                fsm_clear = 1'b1;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    // Without wrap the last pair is held rather than stepped past.
                    if (last && !wrap_q) begin
                        state_d = DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    state_d   = IDLE;
                    fsm_clear = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                fsm_clear = 1'b1;
            end
        endcase
    end

    ab_counter #(
        .IDX_W (IDX_W)
    ) u_counter (
        .clk         (clk),
        .clear       (reset | fsm_clear),
        .step        (step),
        .span_last   (span_last),
        .bunch_last  (bunch_last),
        .bfly_index  (bfly_index),
        .bunch_index (bunch_index),
        .last        (last)
    );

endmodule

// File: tb/tb_ab_selector.sv
// tb/tb_ab_selector.sv - directed self-checking bench for ab_selector
module tb_ab_selector;

    import ab_pkg::*;

    logic              clk;
    logic              reset;
    logic              start;
    logic              en;
    logic [LOGN_W-1:0] log_n;
    logic [LOGN_W-1:0] stage;
    logic              wrap;
    logic [IDX_W-1:0]  bfly_index;
    logic [IDX_W-1:0]  bunch_index;

    int total;
    int bad;

    ab_selector #(
        .IDX_W  (IDX_W),
        .LOGN_W (LOGN_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .en          (en),
        .log_n       (log_n),
        .stage       (stage),
        .wrap        (wrap),
        .bfly_index  (bfly_index),
        .bunch_index (bunch_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pair(input string tag, input int eb, input int ef);
        chk({tag, "_bunch"}, 32'(bunch_index), eb);
        chk({tag, "_bfly"}, 32'(bfly_index), ef);
    endtask

    task automatic chk_state(input string tag, input ab_state_t es);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(es));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        en    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic begin_pass(input int ln, input int st, input logic wr);
        log_n = LOGN_W'(ln);
        stage = LOGN_W'(st);
        wrap  = wr;
        start = 1'b1;
        en    = 1'b1;
        tick();
    endtask

    // log_n=4, stage=1: span 2, 4 bunches
    int t1_bunch [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int t1_bfly  [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};

    ab_addr_t ad;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        en    = 1'b0;
        log_n = '0;
        stage = '0;
        wrap  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_pair("rst", 0, 0);
            chk_state("rst", IDLE);
        end
        reset = 1'b0;

        // wrap pass, log_n=4 stage=1
        begin_pass(4, 1, 1'b1);
        chk_state("t1_run", RUN);
        for (int i = 0; i < 9; i++) begin
            chk_pair($sformatf("t1_%0d", i), t1_bunch[i], t1_bfly[i]);
            tick();
        end
        // reset together with start: reset wins
        reset = 1'b1;
        tick();
        chk_pair("rst_start", 0, 0);
        chk_state("rst_start", IDLE);
        reset = 1'b0;
        start = 1'b0;
        tick();

        // stage 0, no wrap: 8 bunches of 1, then DONE holds (7,0)
        begin_pass(4, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk_pair($sformatf("t2_%0d", i), i, 0);
            tick();
        end
        chk_pair("t2_done", 7, 0);
        chk_state("t2_done", DONE);
        tick();
        chk_pair("t2_hold", 7, 0);
        chk_state("t2_hold", DONE);
        start = 1'b0;
        tick();
        chk_pair("t2_idle", 0, 0);
        chk_state("t2_idle", IDLE);

        // stage 3: one bunch of 8, wraps; log_n/stage edits mid-run ignored
        begin_pass(4, 3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk_pair($sformatf("t3_%0d", i), 0, i);
            tick();
        end
        chk_pair("t3_wrap", 0, 0);
        log_n = 4'd2;
        stage = 4'd0;
        wrap  = 1'b0;
        tick();
        chk_pair("t3_cfg1", 0, 1);
        tick();
        chk_pair("t3_cfg2", 0, 2);
        do_reset();

        // en gating at log_n=3 stage=1
        begin_pass(3, 1, 1'b1);
        chk_pair("t4_a", 0, 0);
        tick();
        chk_pair("t4_b", 0, 1);
        en = 1'b0;
        tick();
        chk_pair("t4_hold1", 0, 1);
        tick();
        chk_pair("t4_hold2", 0, 1);
        en = 1'b1;
        tick();
        chk_pair("t4_c", 1, 0);
        tick();
        chk_pair("t4_d", 1, 1);
        tick();
        chk_pair("t4_e", 0, 0);
        do_reset();

        // stage=9 with log_n=4 clamps to stage 3
        begin_pass(4, 9, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk_pair($sformatf("t5_%0d", i), 0, i);
            tick();
        end
        chk_pair("t5_done", 0, 7);
        chk_state("t5_done", DONE);
        start = 1'b0;
        tick();
        chk_state("t5_idle", IDLE);

        // log_n=0: single pair (0,0)
        begin_pass(0, 0, 1'b0);
        chk_pair("t6_run", 0, 0);
        chk_state("t6_run", RUN);
        tick();
        chk_pair("t6_done", 0, 0);
        chk_state("t6_done", DONE);
        start = 1'b0;
        tick();
        begin_pass(0, 0, 1'b1);
        tick();
        chk_pair("t6_wrap", 0, 0);
        chk_state("t6_wrap", RUN);
        do_reset();

        // reset mid-pass at (2,1)
        begin_pass(4, 1, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk_pair("t7_pre", 2, 1);
        reset = 1'b1;
        tick();
        chk_pair("t7_rst", 0, 0);
        chk_state("t7_rst", IDLE);
        reset = 1'b0;
        start = 1'b0;

        // package address helper
        ad = calc_ab_addr(15'd1, 15'd1, 4'd1);
        chk("addr1_a", 32'(ad.a), 5);
        chk("addr1_b", 32'(ad.b), 7);
        ad = calc_ab_addr(15'd3, 15'd0, 4'd0);
        chk("addr2_a", 32'(ad.a), 6);
        chk("addr2_b", 32'(ad.b), 7);
        ad = calc_ab_addr(15'd0, 15'd5, 4'd3);
        chk("addr3_a", 32'(ad.a), 5);
        chk("addr3_b", 32'(ad.b), 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
